// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Wait-state data-memory responder; optional DMEM_STATS_EN adds
//            saturating read/write access counters.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int N           = 64,
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read_en,
    input  logic         mem_write_en,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] write_data,
    output logic [N-1:0] read_data,
    output logic         read_valid,
    output logic         busy,
    output logic         addr_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
`endif
);

    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic          legal_q, legal_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [N-1:0]  read_data_q, read_data_d;
    logic          read_valid_q, read_valid_d;
    logic          addr_err_q, addr_err_d;
    logic [N-1:0]  mem_q [DEPTH_WORDS];

    logic          req;
    logic          req_legal;
    logic [AW-1:0] req_idx;
    logic          finish;
    logic          act_wr;
    logic          act_legal;
    logic [AW-1:0] act_idx;
    logic [N-1:0]  act_wdata;
    logic          mem_we;

    assign req       = mem_read_en | mem_write_en;
    assign req_idx   = addr[AW+2:3];
    assign req_legal = (addr[2:0] == 3'b000) && ((addr >> (AW + 3)) == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        legal_d = legal_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    is_wr_d = mem_write_en;
                    legal_d = req_legal;
                    idx_d   = req_idx;
                    wdata_d = write_data;
                    cnt_d   = WS;
                    if (WS == 4'd0) begin
                        state_d = ST_DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access completes straight from IDLE, so the
    // live request is used instead of the not-yet-captured copy.
    always_comb begin
        act_wr    = is_wr_q;
        act_legal = legal_q;
        act_idx   = idx_q;
        act_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            act_wr    = mem_write_en;
            act_legal = req_legal;
            act_idx   = req_idx;
            act_wdata = write_data;
        end
    end

    always_comb begin
        mem_we       = finish & act_wr & act_legal & reset;
        read_valid_d = finish & ~act_wr;
        addr_err_d   = finish & ~act_legal;
        read_data_d  = read_data_q;
        if (finish && !act_wr) begin
            read_data_d = act_legal ? mem_q[act_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            is_wr_q      <= 1'b0;
            legal_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            legal_q      <= legal_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[act_idx] <= act_wdata;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign addr_err   = addr_err_q;
    assign busy       = reset & (((state_q == ST_IDLE) & req) | (state_q == ST_WAIT));

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == ST_DONE) begin
            if (is_wr_q) begin
                if (wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
            end else begin
                if (rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Randomized transaction bench with cycle-level reference model for
//            dmem_responder, plus directed checks on a zero-wait-state instance.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int NW    = 64;
    localparam int DEPTH = 128;
    localparam int WS    = 2;

    logic          clk;
    logic          reset;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [NW-1:0] addr;
    logic [NW-1:0] write_data;
    logic [NW-1:0] read_data;
    logic          read_valid;
    logic          busy;
    logic          addr_err;

    logic          rst0_n;
    logic          rd0_en;
    logic          wr0_en;
    logic [NW-1:0] addr0;
    logic [NW-1:0] wdata0;
    logic [NW-1:0] rdata0;
    logic          rv0;
    logic          busy0;
    logic          err0;

`ifdef DMEM_STATS_EN
    logic [31:0]   rd_count, wr_count, rd_count0, wr_count0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.N(NW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .reset(reset), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .read_valid(read_valid), .busy(busy), .addr_err(addr_err)
`ifdef DMEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    dmem_responder #(.N(NW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst0_n), .mem_read_en(rd0_en), .mem_write_en(wr0_en),
        .addr(addr0), .write_data(wdata0), .read_data(rdata0),
        .read_valid(rv0), .busy(busy0), .addr_err(err0)
`ifdef DMEM_STATS_EN
        , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: one access at a time; accepted on a request cycle while
    // idle, busy for WS+1 cycles, then a single completion cycle.
    logic [63:0] mem_m   [DEPTH];
    bit          known_m [DEPTH];

    initial begin : model_cmp
        int          cyc;
        bit          act;
        int          t0;
        bit          m_wr;
        bit          m_ok;
        int          m_idx;
        logic [63:0] m_wd;
        logic [63:0] e_rd;
        bit          e_rd_known;
        bit          e_busy, e_rv, e_err;
        int          c_rd, c_wr;
        bit          inc_rd, inc_wr;
        cyc = 0; act = 0; t0 = 0; m_wr = 0; m_ok = 0; m_idx = 0; m_wd = '0;
        e_rd = '0; e_rd_known = 1; c_rd = 0; c_wr = 0;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            e_busy = 0; e_rv = 0; e_err = 0; inc_rd = 0; inc_wr = 0;
            if (!reset) begin
                act = 0; e_rd = '0; e_rd_known = 1; c_rd = 0; c_wr = 0;
            end else if (act && cyc <= t0 + WS) begin
                e_busy = 1;
            end else if (act && cyc == t0 + WS + 1) begin
                act   = 0;
                e_rv  = !m_wr;
                e_err = !m_ok;
                if (!m_wr) begin
                    inc_rd = 1;
                    if (m_ok) begin
                        e_rd = mem_m[m_idx];
                        e_rd_known = known_m[m_idx];
                    end else begin
                        e_rd = '0;
                        e_rd_known = 1;
                    end
                end else begin
                    inc_wr = 1;
                    if (m_ok) begin
                        mem_m[m_idx]   = m_wd;
                        known_m[m_idx] = 1;
                    end
                end
            end else if (mem_read_en || mem_write_en) begin
                act    = 1;
                t0     = cyc;
                m_wr   = mem_write_en;
                m_ok   = (addr % 8 == 0) && (addr < 64'(DEPTH * 8));
                m_idx  = m_ok ? int'(addr / 8) : 0;
                m_wd   = write_data;
                e_busy = 1;
            end
            chk("busy", {63'd0, busy}, {63'd0, e_busy});
            chk("read_valid", {63'd0, read_valid}, {63'd0, e_rv});
            chk("addr_err", {63'd0, addr_err}, {63'd0, e_err});
            if (e_rd_known) chk("read_data", read_data, e_rd);
`ifdef DMEM_STATS_EN
            chk("rd_count", {32'd0, rd_count}, 64'(c_rd));
            chk("wr_count", {32'd0, wr_count}, 64'(c_wr));
`endif
            if (inc_rd) c_rd++;
            if (inc_wr) c_wr++;
        end
    end

    // Pipeline-like driver: holds the request until the first non-busy cycle,
    // optionally scrambling the inputs while the access is in flight.
    task automatic xfer(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] d, input bit scr,
                        output logic o_rv, output logic o_err, output logic [63:0] o_rd);
        bit done;
        done = 0;
        o_rv = 0; o_err = 0; o_rd = '0;
        mem_read_en = rd; mem_write_en = wr; addr = a; write_data = d;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!busy) begin
                done  = 1;
                o_rv  = read_valid;
                o_err = addr_err;
                o_rd  = read_data;
            end else begin
                @(posedge clk);
                #1;
                if (scr && $urandom_range(0, 2) == 0) begin
                    mem_read_en  = 1'($urandom);
                    mem_write_en = 1'($urandom);
                    addr         = {$urandom, $urandom};
                    write_data   = {$urandom, $urandom};
                end
            end
        end
        chk("xfer_completes", {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
        mem_read_en = 0; mem_write_en = 0;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return 64'($urandom_range(0, DEPTH - 1)) << 3;
        if (r < 18) return (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(1, 7));
        return ({$urandom, $urandom} | 64'h400) & ~64'h7;
    endfunction

    initial begin : stim
        logic        rv, er;
        logic [63:0] rdv;
        int          sel;
        reset = 1; rst0_n = 1;
        mem_read_en = 0; mem_write_en = 0; addr = '0; write_data = '0;
        rd0_en = 0; wr0_en = 0; addr0 = '0; wdata0 = '0;
        #1;
        reset = 0; rst0_n = 0;
        mem_read_en = 1;
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_read_valid", {63'd0, read_valid}, 64'd0);
        chk("reset_addr_err", {63'd0, addr_err}, 64'd0);
        chk("reset_read_data", read_data, 64'd0);
        @(posedge clk); #1;
        mem_read_en = 0;
        reset = 1;

        for (int i = 0; i < DEPTH; i++)
            xfer(0, 1, 64'(i) << 3, {$urandom, $urandom}, 0, rv, er, rdv);
        xfer(0, 1, 64'h0, 64'h1111_2222_3333_4444, 0, rv, er, rdv);
        xfer(0, 1, 64'h20, 64'h1234, 0, rv, er, rdv);

        // Write 0x10 then read it back with exact cycle timing.
        mem_write_en = 1; addr = 64'h10; write_data = 64'hDEAD_BEEF_0000_0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("wr_busy_T+n", {63'd0, busy}, 64'd1);
        end
        @(negedge clk);
        chk("wr_busy_T+3", {63'd0, busy}, 64'd0);
        chk("wr_no_valid", {63'd0, read_valid}, 64'd0);
        @(posedge clk); #1;
        mem_write_en = 0; mem_read_en = 1; addr = 64'h10;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("rd_valid_T+7", {63'd0, read_valid}, 64'd1);
        chk("rd_data_T+7", read_data, 64'hDEAD_BEEF_0000_0001);
        @(posedge clk); #1;
        mem_read_en = 0;

        xfer(1, 0, 64'h13, '0, 0, rv, er, rdv);
        chk("misaligned_err", {63'd0, er}, 64'd1);
        chk("misaligned_valid", {63'd0, rv}, 64'd1);
        chk("misaligned_data", rdv, 64'd0);
        xfer(0, 1, 64'h400, 64'hFFFF, 0, rv, er, rdv);
        chk("oor_write_err", {63'd0, er}, 64'd1);
        xfer(1, 0, 64'h0, '0, 0, rv, er, rdv);
        chk("oor_kept_word0", rdv, 64'h1111_2222_3333_4444);
        chk("legal_no_err", {63'd0, er}, 64'd0);

        xfer(1, 1, 64'h8, 64'h5, 0, rv, er, rdv);
        chk("both_no_valid", {63'd0, rv}, 64'd0);
        xfer(1, 0, 64'h8, '0, 0, rv, er, rdv);
        chk("both_wrote", rdv, 64'h5);

        // Abort a write during its first wait cycle.
        mem_write_en = 1; addr = 64'h20; write_data = 64'hAA;
        @(posedge clk); #1;
        reset = 0; mem_write_en = 0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_valid", {63'd0, read_valid}, 64'd0);
        @(posedge clk); #1;
        reset = 1;
        xfer(1, 0, 64'h20, '0, 0, rv, er, rdv);
        chk("abort_kept", rdv, 64'h1234);

        for (int t = 0; t < 300; t++) begin
            int g;
            g = int'($urandom_range(0, 2));
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            sel = int'($urandom_range(0, 19));
            xfer(sel < 9, sel >= 8, rand_addr(), {$urandom, $urandom}, 1, rv, er, rdv);
        end

        // Zero-wait-state instance: completion straight from IDLE.
        @(posedge clk); #1;
        rst0_n = 1;
        @(posedge clk); #1;
        wr0_en = 1; addr0 = 64'h0; wdata0 = 64'h77;
        @(negedge clk);
        chk("ws0_wr_busy_T", {63'd0, busy0}, 64'd1);
        @(negedge clk);
        chk("ws0_wr_busy_T+1", {63'd0, busy0}, 64'd0);
        chk("ws0_wr_err", {63'd0, err0}, 64'd0);
        @(posedge clk); #1;
        wr0_en = 0;
        rst0_n = 0;
        @(negedge clk);
        chk("ws0_reset_data", rdata0, 64'd0);
        @(posedge clk); #1;
        rst0_n = 1;
        @(posedge clk); #1;
        rd0_en = 1; addr0 = 64'h0;
        @(negedge clk);
        chk("ws0_rd_busy_T", {63'd0, busy0}, 64'd1);
        chk("ws0_rd_novalid_T", {63'd0, rv0}, 64'd0);
        @(negedge clk);
        chk("ws0_rd_busy_T+1", {63'd0, busy0}, 64'd0);
        chk("ws0_rd_valid_T+1", {63'd0, rv0}, 64'd1);
        chk("ws0_rd_data_T+1", rdata0, 64'h77);
        @(negedge clk);
        chk("ws0_accept_T+2", {63'd0, busy0}, 64'd1);
        @(posedge clk); #1;
        rd0_en = 0;
        @(negedge clk);
        chk("ws0_valid_T+3", {63'd0, rv0}, 64'd1);
        @(negedge clk);
        chk("ws0_idle_valid", {63'd0, rv0}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the pipeline's DM interface. It accepts the MEM-stage read and write strobes, address and write data, and serves them from an internal word array after a fixed number of wait states. It returns `read_data` with a one-cycle `read_valid` pulse and raises `busy` so the hazard logic can freeze the pipeline while an access is in flight.

Parameters:
- N, 64, data and address width in bits.
- DEPTH_WORDS, 128, number of N-bit words (power of 2).
- WAIT_STATES, 2, extra cycles per access (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read_en  in  1  read request (DM_readEnable).
- mem_write_en  in  1  write request (DM_writeEnable).
- addr  in  N  byte address (DM_addr).
- write_data  in  N  store data (DM_writeData).
- read_data  out  N  load data (DM_readData).
- read_valid  out  1  one-cycle pulse: `read_data` is valid.
- busy  out  1  stall request to the hazard logic.
- addr_err  out  1  one-cycle pulse: misaligned or out-of-range access.

Behaviour:
- Word index: idx = addr[log2(DEPTH_WORDS)+2:3].
- Address is legal only when addr[2:0]==0 and addr < DEPTH_WORDS*8.
- States: IDLE, WAIT, DONE. State register and all outputs are reset asynchronously while reset==0.
- Reset values: state=IDLE, counter=0, read_data=0, read_valid=0, addr_err=0. `busy` is 0 while reset is asserted.
- The array is not reset; its contents are preserved across reset.
- A request is (mem_read_en | mem_write_en) sampled in IDLE. On such a cycle T:
  - capture op, idx, write_data and legality into registers;
  - load the counter with WAIT_STATES;
  - go to WAIT if WAIT_STATES>0, otherwise go to DONE.
- WAIT: decrement the counter each cycle; when counter==1, go to DONE next. The block spends exactly WAIT_STATES cycles in WAIT.
- DONE (one cycle, entered on the edge that ends the last WAIT cycle):
  - Legal write: the array word is updated on that edge.
  - Legal read: read_data is loaded from the array on the same edge; read_valid=1 during DONE.
  - Illegal access: the write is dropped, read_data=0, read_valid=1 for reads, addr_err=1 during DONE.
  - Next state is always IDLE.
- DONE ignores request inputs, because the stalled pipeline still presents the same request.
- busy = (state==IDLE & request) | (state==WAIT). It is low in DONE so the pipeline advances at the end of DONE.
- Read latency: read_valid is high in cycle T+WAIT_STATES+1. A write completes on the same edge.
- read_data holds its value until the next read completes. read_valid is low outside DONE.
- mem_read_en and mem_write_en both high: treated as a write; read_valid stays 0.
- Request inputs that change during WAIT are ignored; the captured values are used.
- Reset asserted mid-access: the access is abandoned, no array write occurs, and the block returns to IDLE with outputs at reset values.

Optional Feature:
DMEM_STATS_EN
- Defined: adds outputs rd_count[31:0] and wr_count[31:0], both reset to 0 asynchronously.
  - rd_count increments in each DONE cycle of a read, legal or illegal.
  - wr_count increments in each DONE cycle of a write, legal or illegal.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write then read, WAIT_STATES=2:
  - write addr=0x10, data=0xDEADBEEF_00000001 at T → busy=1 in T..T+2, busy=0 in T+3.
  - read addr=0x10 at T+4 → read_valid=1 and read_data=0xDEADBEEF_00000001 in T+7.
- WAIT_STATES=0: read addr=0x0 after reset → busy=1 in T only; read_valid in T+1; DONE ignores the still-present request; next request accepted at T+2.
- Illegal accesses:
  - read addr=0x13 → addr_err=1, read_valid=1, read_data=0.
  - write addr=0x400 (DEPTH_WORDS=128) → addr_err=1; a following read of addr=0x0 returns its prior value.
- Simultaneous strobes: mem_read_en=mem_write_en=1, addr=0x8, data=0x5 → no read_valid; a later read of 0x8 returns 0x5.
- Reset mid-access: drive reset=0 in the first WAIT cycle of a write of 0xAA to 0x20 → state=IDLE, busy=0; a later read of 0x20 returns its old value.
- DMEM_STATS_EN defined: 3 reads + 2 writes (one illegal) → rd_count=3, wr_count=2; after reset both are 0.
